// File: rtl/alu_seq.sv
// Registered ALU with single-cycle logic/arith/shift ops and a WIDTH-cycle shift-add multiply.
// Start/Busy/Done handshake; Q and Z/N/C/V update only on the Done cycle.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [3:0]       s_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] q_o,
  output logic             z_o,
  output logic             n_o,
  output logic             c_o,
  output logic             v_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ZERO  = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_PASSA = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_INC   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_SRA   = 4'd10;
  localparam logic [3:0] OP_MUL   = 4'd11;

  typedef enum logic {IDLE, MUL} state_t;

  state_t               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic                 done_q, done_d;

  // Single-cycle datapath
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;
  logic [WIDTH:0]       add_x, inc_x, shl_x, shr_x;
  logic signed [WIDTH:0] sra_x;
  logic [SHW-1:0]       sh;
  logic [WIDTH:0]       mul_sum;

  always_comb begin
    sh    = b_i[SHW-1:0];
    add_x = {1'b0, a_i} + {1'b0, b_i};
    inc_x = {1'b0, a_i} + {{WIDTH{1'b0}}, 1'b1};
    // The extra bit catches the last bit shifted out; it stays 0 for a zero shift.
    shl_x = {1'b0, a_i} << sh;
    shr_x = {a_i, 1'b0} >> sh;
    sra_x = $signed({a_i, 1'b0}) >>> sh;

    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (s_i)
      OP_ADD: begin
        alu_res = add_x[WIDTH-1:0];
        alu_c   = add_x[WIDTH];
        alu_v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (alu_res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = a_i - b_i;
        alu_c   = (a_i >= b_i);
        alu_v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (alu_res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_PASSA: alu_res = a_i;
      OP_XOR:   alu_res = a_i ^ b_i;
      OP_OR:    alu_res = a_i | b_i;
      OP_AND:   alu_res = a_i & b_i;
      OP_INC: begin
        alu_res = inc_x[WIDTH-1:0];
        alu_c   = inc_x[WIDTH];
        alu_v   = !a_i[WIDTH-1] && alu_res[WIDTH-1];
      end
      OP_SHL: begin
        alu_res = shl_x[WIDTH-1:0];
        alu_c   = shl_x[WIDTH];
      end
      OP_SHR: begin
        alu_res = shr_x[WIDTH:1];
        alu_c   = shr_x[0];
      end
      OP_SRA: begin
        alu_res = sra_x[WIDTH:1];
        alu_c   = sra_x[0];
      end
      default: begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
    endcase
  end

  // Multiplier step: conditionally add multiplicand into the high half, then shift right.
  assign mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    q_d     = q_q;
    z_d     = z_q;
    n_d     = n_q;
    c_d     = c_q;
    v_d     = v_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (s_i == OP_MUL) begin
            state_d = MUL;
            cnt_d   = '0;
            mcand_d = a_i;
            prod_d  = {{WIDTH{1'b0}}, b_i};
          end else begin
            q_d    = alu_res;
            z_d    = (alu_res == '0);
            n_d    = alu_res[WIDTH-1];
            c_d    = alu_c;
            v_d    = alu_v;
            done_d = 1'b1;
          end
        end
      end
      MUL: begin
        prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d = IDLE;
          q_d     = prod_d[WIDTH-1:0];
          z_d     = (prod_d[WIDTH-1:0] == '0);
          n_d     = prod_d[WIDTH-1];
          c_d     = |prod_d[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      q_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      q_q     <= q_d;
      z_q     <= z_d;
      n_q     <= n_d;
      c_q     <= c_d;
      v_q     <= v_d;
      done_q  <= done_d;
    end
  end

  assign q_o    = q_q;
  assign z_o    = z_q;
  assign n_o    = n_q;
  assign c_o    = c_q;
  assign v_o    = v_q;
  assign busy_o = (state_q == MUL);
  assign done_o = done_q;

endmodule
